vga_scan: RTL and testbench

VGA_SCAN -- requirements
Module: vga_scan

---
 rtl/vga_scan.sv | 136 +++++++++++++
 tb/tb_vga_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan.sv
// vga_scan: VGA raster timing generator.
// Free-running h/v counters (gated by en) drive x/y directly; sync, data
// enable and blanked colour are registered one enabled clock behind x/y.
module vga_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);
    // Boundaries are summed at full int width, then narrowed once to the
    // 16-bit counter width so the compares are plain unsigned 16-bit.
    localparam int          H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [15:0] H_ACT_W    = 16'(H_ACTIVE);
    localparam logic [15:0] H_SYNC_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_END = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_ACT_W    = 16'(V_ACTIVE);
    localparam logic [15:0] V_SYNC_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SYNC_END = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
    localparam bit          SYNC_ON    = SYNC_POL;
    localparam bit          SYNC_OFF   = !SYNC_POL;

    logic [15:0] h_cnt_q, h_cnt_d;
    logic [15:0] v_cnt_q, v_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  g_q, g_d;
    logic [7:0]  b_q, b_d;
    logic        h_wrap;
    logic        v_wrap;
    logic        visible;
    logic        h_sync_on;
    logic        v_sync_on;

    // Decode the raster position presented on x/y this cycle
    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        v_wrap    = (v_cnt_q == V_LAST);
        visible   = (h_cnt_q < H_ACT_W) && (v_cnt_q < V_ACT_W);
        h_sync_on = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q <= H_SYNC_END);
        v_sync_on = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q <= V_SYNC_END);
    end

    // Next state: everything holds unless en, then counters step and the output stage loads
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        de_d        = de_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        if (en) begin
            h_cnt_d = h_wrap ? 16'd0 : h_cnt_q + 16'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? 16'd0 : v_cnt_q + 16'd1;
            end
            if (h_wrap && v_wrap) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            hs_d = h_sync_on ? SYNC_ON : SYNC_OFF;
            vs_d = v_sync_on ? SYNC_ON : SYNC_OFF;
            de_d = visible;
            r_d  = visible ? pix_r : 8'h00;
            g_d  = visible ? pix_g : 8'h00;
            b_d  = visible ? pix_b : 8'h00;
        end
    end

    // State registers; reset parks the raster at the frame origin with syncs idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= 16'd0;
            v_cnt_q     <= 16'd0;
            frame_cnt_q <= 16'd0;
            hs_q        <= SYNC_OFF;
            vs_q        <= SYNC_OFF;
            de_q        <= 1'b0;
            r_q         <= 8'h00;
            g_q         <= 8'h00;
            b_q         <= 8'h00;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    // Gated by rst_n because the counters sit at the origin throughout reset.
    assign frame_start = rst_n && en && (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
    assign frame_cnt   = frame_cnt_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: bench for vga_scan using a reduced raster so whole frames stay short.
module tb_vga_scan;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 25
    localparam int VT = VA + VF + VS + VB;   // 15
    localparam bit POL = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [15:0] x, y, frame_cnt;
    logic        frame_start, vga_hs, vga_vs, vga_de;
    logic [7:0]  vga_r, vga_g, vga_b;

    vga_scan #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .x(x), .y(y), .frame_start(frame_start), .frame_cnt(frame_cnt),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    // Reference model state: raster position, frame count, expected registered outputs
    int         mx, my, e_fc;
    logic       e_hs, e_vs, e_de;
    logic [7:0] e_r, e_g, e_b;
    int         n_chk = 0, n_pass = 0, pulses = 0;

    typedef struct {
        int         tx;
        int         ty;
        logic [7:0] pix;
        logic       e_de;
        logic       e_hs;
        logic       e_vs;
        logic [7:0] e_rgb;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        mx = 0; my = 0; e_fc = 0;
        e_hs = ~POL; e_vs = ~POL; e_de = 1'b0;
        e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_vga_de"}, vga_de, e_de);
        check({tag, "_vga_hs"}, vga_hs, e_hs);
        check({tag, "_vga_vs"}, vga_vs, e_vs);
        check({tag, "_vga_r"}, vga_r, e_r);
        check({tag, "_vga_g"}, vga_g, e_g);
        check({tag, "_vga_b"}, vga_b, e_b);
        check({tag, "_frame_cnt"}, frame_cnt, e_fc[15:0]);
    endtask

    task automatic rand_pix();
        pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
    endtask

    // One clock: check position/frame_start, predict the edge, then check registered outputs
    task automatic tick();
        logic vis;
        #1;
        check("x", x, mx);
        check("y", y, my);
        check("frame_start", frame_start, (rst_n && en && mx == 0 && my == 0));
        if (frame_start) pulses++;
        if (rst_n && en) begin
            vis  = (mx < HA) && (my < VA);
            e_de = vis;
            e_r  = vis ? pix_r : 8'h00;
            e_g  = vis ? pix_g : 8'h00;
            e_b  = vis ? pix_b : 8'h00;
            e_hs = (mx >= HA + HF && mx < HA + HF + HS) ? POL : ~POL;
            e_vs = (my >= VA + VF && my < VA + VF + VS) ? POL : ~POL;
            if (mx == HT - 1 && my == VT - 1) e_fc = (e_fc + 1) % 65536;
            mx = (mx + 1) % HT;
            if (mx == 0) my = (my + 1) % VT;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs("tick");
    endtask

    task automatic run_to(input int tx, input int ty);
        int n;
        n = 0;
        while (!(mx == tx && my == ty) && n < 4 * HT * VT) begin
            rand_pix();
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Boundary table: coordinate presented, pixel driven there, outputs one clock later
        tbl[0]  = '{0,  0,  8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};
        tbl[1]  = '{15, 0,  8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};
        tbl[2]  = '{16, 0,  8'hFF, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[3]  = '{17, 0,  8'hFF, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[4]  = '{18, 0,  8'hFF, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[5]  = '{21, 0,  8'hFF, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[6]  = '{22, 0,  8'hFF, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[7]  = '{5,  7,  8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
        tbl[8]  = '{5,  8,  8'hFF, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[9]  = '{0,  10, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{20, 11, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{24, 11, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[12] = '{0,  12, 8'hAA, 1'b0, 1'b1, 1'b1, 8'h00};

        rst_n = 1'b0; en = 1'b1; pix_r = 8'h00; pix_g = 8'h00; pix_b = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_x", x, 0);
        check("reset_y", y, 0);
        check("reset_frame_start", frame_start, 0);
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven boundary vectors
        for (int i = 0; i < 13; i++) begin
            run_to(tbl[i].tx, tbl[i].ty);
            pix_r = tbl[i].pix; pix_g = tbl[i].pix; pix_b = tbl[i].pix;
            tick();
            check($sformatf("tbl%0d_de", i), vga_de, tbl[i].e_de);
            check($sformatf("tbl%0d_hs", i), vga_hs, tbl[i].e_hs);
            check($sformatf("tbl%0d_vs", i), vga_vs, tbl[i].e_vs);
            check($sformatf("tbl%0d_rgb", i), {vga_r, vga_g, vga_b},
                  {tbl[i].e_rgb, tbl[i].e_rgb, tbl[i].e_rgb});
        end

        // Enable stall: freeze for 10 clocks mid-line, resume at the next pixel
        run_to(10, 3);
        en = 1'b0;
        repeat (10) begin
            rand_pix();
            tick();
        end
        check("stall_x", x, 10);
        check("stall_y", y, 3);
        en = 1'b1;
        tick();
        check("resume_x", x, 11);

        // Randomized enable and pixels against the model
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 9) != 0);
            rand_pix();
            tick();
        end
        en = 1'b1;

        // Asynchronous reset mid-frame, between clock edges
        run_to(12, 5);
        check("pre_reset_frame_cnt_nonzero", (frame_cnt != 16'd0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_x", x, 0);
        check("async_y", y, 0);
        check("async_frame_start", frame_start, 0);
        check_outputs("async");
        @(negedge clk);
        repeat (2) begin
            rand_pix();
            tick();
        end
        rst_n = 1'b1;

        // Two full frames from release: three frame_start pulses, frame_cnt = 2
        pulses = 0;
        for (int i = 0; i < 2 * HT * VT + 1; i++) begin
            rand_pix();
            tick();
        end
        check("wrap_pulses", pulses, 3);
        check("wrap_frame_cnt", frame_cnt, 2);
        check("wrap_x", x, 1);
        check("wrap_y", y, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
